extensor_pipe: RTL and testbench
================================

EXTENSOR_PIPE -- requirements
Module: extensor_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the extended result width; legal only if DATA_W >= IMM_W.
REQ-002 The block SHALL have parameter IMM_W, default 21, meaning the raw immediate bus width; legal only if IMM_W >= 21.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning output buffer entries; legal only as a power of 2, >= 2.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port inValid, input, 1 bit: request present.
REQ-007 The block SHALL have port inReady, output, 1 bit: block can accept a request.
REQ-008 The block SHALL have port immRaw, input, IMM_W bits: raw immediate, right-aligned.
REQ-009 The block SHALL have port selectSize, input, 3 bits: field width code 000=16, 001=21, 010=9, 011=18, 100=12; 101-111 illegal.
REQ-010 The block SHALL have port signMode, input, 1 bit: 1 = sign-extend, 0 = zero-extend.
REQ-011 The block SHALL have port shiftAmt, input, 2 bits: left shift applied after extension, 0-3.
REQ-012 The block SHALL have port outValid, output, 1 bit: head entry valid.
REQ-013 The block SHALL have port outReady, input, 1 bit: consumer takes head entry.
REQ-014 The block SHALL have port out32, output, DATA_W bits: extended result of the head entry.
REQ-015 The block SHALL have port outErr, output, 1 bit: head entry came from an illegal selectSize.
REQ-016 The block SHALL have port occupancy, output, log2(DEPTH)+1 bits: entries held.
REQ-017 The block SHALL have port errCount, output, 8 bits: saturating count of accepted illegal requests.

Function
REQ-018 Push SHALL occur when inValid and inReady are both 1 at a rising edge; pop SHALL occur when outValid and outReady are both 1 at a rising edge.
REQ-019 inReady SHALL equal (occupancy < DEPTH) and SHALL NOT depend combinationally on outReady or any other input.
REQ-020 outValid SHALL equal (occupancy != 0); out32 and outErr SHALL present the oldest entry and SHALL hold stable while outValid=1 and outReady=0.
REQ-021 Result computation: take the low W bits of immRaw (W per selectSize); ignore immRaw bits at positions >= W.
REQ-022 Result computation: fill bits W..DATA_W-1 with immRaw[W-1] when signMode=1, else with 0.
REQ-023 Result computation: shift left by shiftAmt with zero fill; bits shifted past DATA_W-1 are dropped.
REQ-024 An illegal selectSize SHALL store result 0 with outErr=1; legal codes SHALL store outErr=0.
REQ-025 Latency SHALL be one cycle: a request pushed at edge N into an empty buffer SHALL be visible on out32/outValid immediately after edge N.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-027 Push without pop SHALL increment occupancy; pop without push SHALL decrement it.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 When full, inReady=0 and no push SHALL occur even if a pop occurs in the same edge; inReady SHALL rise the cycle after that pop.
REQ-030 errCount SHALL increment by 1 on each push of an illegal request and SHALL saturate at 255.
REQ-031 Buffer entries SHALL be accepted only by handshake; inputs presented while inReady=0 SHALL be ignored.

Reset
REQ-032 While reset=0, the block SHALL immediately, without a clock, force occupancy=0, pointers=0, outValid=0, errCount=0, out32=0, outErr=0, and inReady=1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries; no entry SHALL appear after reset deasserts.
REQ-034 The first push SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-035 Sign extension: immRaw=0x00FFF, selectSize=100, signMode=1, shiftAmt=0, outReady=1 -> out32=0xFFFFFFFF and outErr=0 one cycle later; the same with signMode=0 -> out32=0x00000FFF.
REQ-036 Shift and ignored upper bits: immRaw=0x1F100, selectSize=010, signMode=1, shiftAmt=2 -> out32=0xFFFFFC00.
REQ-037 Fill and back-pressure: outReady=0, push 5 requests back-to-back -> occupancy reaches 4, inReady=0, 5th request not accepted; then outReady=1 -> 4 results drain in order, and inReady=1 the cycle after the first pop.
REQ-038 Illegal code: selectSize=111 -> out32=0, outErr=1, errCount=1; 300 illegal pushes -> errCount=255.
REQ-039 Simultaneous push/pop at occupancy=2 for 10 cycles -> occupancy stays 2 and output order matches input order.
REQ-040 Asynchronous reset: assert reset=0 mid-cycle with occupancy=3 -> outValid=0 and occupancy=0 before the next clock edge, and no stale data after release.

Source files
------------

// File: rtl/extensor_pipe.sv
// extensor_pipe: immediate extender feeding a small output FIFO.
// Each accepted request selects a field width, sign- or zero-extends that
// field to DATA_W bits, shifts it left by 0-3 and queues the result. The
// head entry appears on out32/outErr the cycle after it is pushed.
module extensor_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 21,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [IMM_W-1:0]           immRaw,
  input  logic [2:0]                 selectSize,
  input  logic                       signMode,
  input  logic [1:0]                 shiftAmt,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [DATA_W-1:0]          out32,
  output logic                       outErr,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [7:0]                 errCount
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // ---------------------------------------------------------------------
  // Result computation
  // ---------------------------------------------------------------------
  logic [31:0]       field_w;
  logic              sign_bit;
  logic              legal;
  logic              fill_bit;
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] new_data;

  // Decode the width code; the sign bit is picked per code so each case
  // uses a constant bit index.
  always_comb begin
    field_w  = 32'd0;
    sign_bit = 1'b0;
    legal    = 1'b1;
    case (selectSize)
      3'b000: begin field_w = 32'd16; sign_bit = immRaw[15]; end
      3'b001: begin field_w = 32'd21; sign_bit = immRaw[20]; end
      3'b010: begin field_w = 32'd9;  sign_bit = immRaw[8];  end
      3'b011: begin field_w = 32'd18; sign_bit = immRaw[17]; end
      3'b100: begin field_w = 32'd12; sign_bit = immRaw[11]; end
      default: legal = 1'b0;
    endcase
  end

  assign fill_bit = signMode & sign_bit;

  // Bits inside the field come from immRaw; everything above is fill.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < IMM_W) begin : g_imm
        assign ext_val[gi] = (32'(gi) < field_w) ? immRaw[gi] : fill_bit;
      end else begin : g_fill
        assign ext_val[gi] = fill_bit;
      end
    end
  endgenerate

  // Illegal codes store a zero result, flagged through the error bit.
  assign new_data = legal ? (ext_val << shiftAmt) : '0;

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     count_reg,  count_next;
  logic [7:0]      err_cnt_reg, err_cnt_next;
  logic            push;
  logic            pop;
  logic [DATA_W:0] head;

  // Ready and valid come only from the registered count.
  assign inReady  = (count_reg != FULL_CNT);
  assign outValid = (count_reg != '0);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;

  // Next-state for pointers, occupancy and the saturating error counter.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    err_cnt_next = err_cnt_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    if (push && !legal && (err_cnt_reg != 8'hFF)) begin
      err_cnt_next = err_cnt_reg + 8'd1;
    end
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_cnt_reg <= '0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Entry storage; contents need no reset because the count gates them.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {~legal, new_data};
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign out32     = outValid ? head[DATA_W-1:0] : '0;
  assign outErr    = outValid & head[DATA_W];
  assign occupancy = count_reg;
  assign errCount  = err_cnt_reg;

endmodule

// File: tb/tb_extensor_pipe.sv
// tb_extensor_pipe: directed stimulus with a queue scoreboard for extensor_pipe.
module tb_extensor_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [20:0] immRaw = '0;
  logic [2:0]  selectSize = '0;
  logic        signMode = 1'b0;
  logic [1:0]  shiftAmt = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] out32;
  logic        outErr;
  logic [2:0]  occupancy;
  logic [7:0]  errCount;

  logic [32:0] sb_q[$];
  int occ_mdl = 0;
  int err_mdl = 0;
  int checks  = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  extensor_pipe #(.DATA_W(32), .IMM_W(21), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .immRaw(immRaw), .selectSize(selectSize), .signMode(signMode), .shiftAmt(shiftAmt),
    .outValid(outValid), .outReady(outReady),
    .out32(out32), .outErr(outErr),
    .occupancy(occupancy), .errCount(errCount)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {err, data}: mask the field, OR in ones above it when negative.
  function automatic logic [32:0] model(input logic [20:0] imm, input logic [2:0] sel,
                                        input logic sm, input logic [1:0] sh);
    int w;
    logic [31:0] mask;
    logic [31:0] v;
    case (sel)
      3'd0: w = 16;
      3'd1: w = 21;
      3'd2: w = 9;
      3'd3: w = 18;
      3'd4: w = 12;
      default: return {1'b1, 32'd0};
    endcase
    mask = (32'd1 << w) - 32'd1;
    v = {11'd0, imm} & mask;
    if (sm && v[w-1]) v = v | ~mask;
    v = v << sh;
    return {1'b0, v};
  endfunction

  // One clock: drive at negedge, check state and any popped head, advance model.
  task automatic cycle(input logic v, input logic [20:0] imm, input logic [2:0] sel,
                       input logic sm, input logic [1:0] sh, input logic ordy);
    logic [32:0] exp;
    logic do_pop;
    logic do_push;
    @(negedge clock);
    inValid = v; immRaw = imm; selectSize = sel; signMode = sm; shiftAmt = sh; outReady = ordy;
    #1;
    check("inReady",   33'(inReady),   33'(occ_mdl < 4));
    check("outValid",  33'(outValid),  33'(occ_mdl != 0));
    check("occupancy", 33'(occupancy), 33'(occ_mdl));
    check("errCount",  33'(errCount),  33'(err_mdl));
    do_pop  = (occ_mdl != 0) && ordy;
    do_push = v && (occ_mdl < 4);
    if (do_pop) begin
      exp = sb_q.pop_front();
      check("head", {outErr, out32}, exp);
      $display("pop  data=%h err=%b exp_data=%h exp_err=%b", out32, outErr, exp[31:0], exp[32]);
    end
    if (do_push) begin
      sb_q.push_back(model(imm, sel, sm, sh));
      if (sel > 3'd4 && err_mdl < 255) err_mdl++;
      $display("push imm=%h sel=%0d sign=%b shift=%0d", imm, sel, sm, sh);
    end
    occ_mdl = occ_mdl + int'(do_push) - int'(do_pop);
    @(posedge clock);
    #1;
    inValid = 1'b0;
  endtask

  // Inspect the head shortly after an edge, before the next negedge.
  task automatic peek(input string tag, input logic [32:0] exp);
    #2;
    check(tag, {outErr, out32}, exp);
  endtask

  initial begin
    // Reset state, held from time zero.
    #1;
    check("rst_outValid",  33'(outValid),  33'd0);
    check("rst_inReady",   33'(inReady),   33'd1);
    check("rst_occupancy", 33'(occupancy), 33'd0);
    check("rst_out32",     {outErr, out32}, 33'd0);
    check("rst_errCount",  33'(errCount),  33'd0);
    #11 reset = 1'b1;

    // Sign/zero extension of a 12-bit field.
    cycle(1'b1, 21'h00FFF, 3'b100, 1'b1, 2'd0, 1'b1);
    peek("sext12", {1'b0, 32'hFFFFFFFF});
    cycle(1'b1, 21'h00FFF, 3'b100, 1'b0, 2'd0, 1'b1);
    peek("zext12", {1'b0, 32'h00000FFF});
    // Shift with ignored upper bits.
    cycle(1'b1, 21'h1F100, 3'b010, 1'b1, 2'd2, 1'b1);
    peek("shift9", {1'b0, 32'hFFFFFC00});
    // Illegal code.
    cycle(1'b1, 21'h1ABCD, 3'b111, 1'b1, 2'd1, 1'b1);
    peek("illegal", {1'b1, 32'd0});
    check("errCount1", 33'(errCount), 33'd1);
    cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    // Random legal traffic with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom), 21'($urandom), 3'($urandom_range(4, 0)),
            1'($urandom), 2'($urandom), 1'($urandom));
    end
    while (occ_mdl != 0) cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    // Fill and back-pressure: the fifth request must be ignored.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 21'(21'h100 + i), 3'b001, 1'b0, 2'd0, 1'b0);
    end
    check("full_occ", 33'(occupancy), 33'd4);
    check("full_rdy", 33'(inReady),   33'd0);
    // Pop while full with a request present: no push on that edge.
    cycle(1'b1, 21'h0DEAD, 3'b001, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);
    cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    // Simultaneous push/pop at occupancy 2.
    cycle(1'b1, 21'h12345, 3'b000, 1'b1, 2'd1, 1'b0);
    cycle(1'b1, 21'h0F0F0, 3'b011, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 21'($urandom), 3'($urandom_range(4, 0)), 1'($urandom), 2'($urandom), 1'b1);
    end
    check("pp_occ", 33'(occupancy), 33'd2);
    while (occ_mdl != 0) cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    // errCount saturation.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 21'($urandom), 3'($urandom_range(7, 5)), 1'b1, 2'd0, 1'b1);
    end
    #2;
    check("errSat", 33'(errCount), 33'd255);
    while (occ_mdl != 0) cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 21'(21'h0AA0 + i), 3'b100, 1'b0, 2'd0, 1'b0);
    end
    #2 reset = 1'b0;
    #1;
    check("arst_outValid",  33'(outValid),  33'd0);
    check("arst_occupancy", 33'(occupancy), 33'd0);
    check("arst_inReady",   33'(inReady),   33'd1);
    check("arst_out32",     {outErr, out32}, 33'd0);
    check("arst_errCount",  33'(errCount),  33'd0);
    sb_q.delete();
    occ_mdl = 0;
    err_mdl = 0;
    @(posedge clock);
    #2 reset = 1'b1;
    // First edge after release accepts a push; nothing stale precedes it.
    cycle(1'b1, 21'h00800, 3'b100, 1'b1, 2'd0, 1'b0);
    peek("post_rst", {1'b0, 32'hFFFFF800});
    cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);
    cycle(1'b0, 21'd0, 3'd0, 1'b0, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
